// File: rtl/health_tracker.sv
// Per-player health, i-frame and death tracking for the 1v1 fight, one cycle per video frame.
// Optional HEALTH_REGEN_EN adds slow health regeneration while a damaged player stays READY.
module health_tracker #(
  parameter logic [2:0] MAX_HEALTH   = 3'd5,
  parameter logic [2:0] HEAVY_DMG    = 3'd2,
  parameter int         IFRAMES      = 30,
  parameter int         REGEN_FRAMES = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] game_state,
  input  logic       p1_hit,
  input  logic       p2_hit,
  input  logic       p1_heavy,
  input  logic       p2_heavy,
  input  logic       p1_block,
  input  logic       p2_block,
  output logic [2:0] player1_health,
  output logic [2:0] player2_health,
  output logic       p1_invuln,
  output logic       p2_invuln,
  output logic       p1_dmg_ack,
  output logic       p2_dmg_ack
);

  localparam int CNT_W = (IFRAMES > 1) ? $clog2(IFRAMES) : 1;

  typedef enum logic [1:0] {READY, IFRAME, DEAD} state_t;

  function automatic logic [2:0] sat_sub(input logic [2:0] h, input logic [2:0] d);
    return (h > d) ? h - d : 3'd0;
  endfunction

  logic [1:0]       hit_in, heavy_in, block_in;
  logic [1:0]       hit_q, hit_d, ack_q, ack_d;
  logic [2:0]       health_q [2];
  logic [2:0]       health_d [2];
  state_t           state_q  [2];
  state_t           state_d  [2];
  logic [CNT_W-1:0] cnt_q    [2];
  logic [CNT_W-1:0] cnt_d    [2];

`ifdef HEALTH_REGEN_EN
  localparam int RG_W = (REGEN_FRAMES > 1) ? $clog2(REGEN_FRAMES) : 1;
  logic [RG_W-1:0]  regen_q  [2];
  logic [RG_W-1:0]  regen_d  [2];
`endif

  assign hit_in   = {p2_hit, p1_hit};
  assign heavy_in = {p2_heavy, p1_heavy};
  assign block_in = {p2_block, p1_block};

  always_comb begin
    hit_d = hit_in;
    ack_d = 2'b00;
    for (int i = 0; i < 2; i++) begin
      health_d[i] = health_q[i];
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
`ifdef HEALTH_REGEN_EN
      regen_d[i]  = '0;
`endif
      case (game_state)
        3'd2: begin
          case (state_q[i])
            READY: begin
              if (hit_in[i] && !hit_q[i] && !block_in[i]) begin
                health_d[i] = sat_sub(health_q[i], heavy_in[i] ? HEAVY_DMG : 3'd1);
                ack_d[i]    = 1'b1;
                if (health_d[i] == 3'd0) begin
                  state_d[i] = DEAD;
                end else begin
                  state_d[i] = IFRAME;
                  cnt_d[i]   = CNT_W'(IFRAMES - 1);
                end
              end
`ifdef HEALTH_REGEN_EN
              else if (health_q[i] != 3'd0 && health_q[i] < MAX_HEALTH) begin
                if (regen_q[i] == RG_W'(REGEN_FRAMES - 1)) begin
                  health_d[i] = health_q[i] + 3'd1;
                end else begin
                  regen_d[i] = regen_q[i] + 1'b1;
                end
              end
`endif
            end
            IFRAME: begin
              if (cnt_q[i] == '0) begin
                state_d[i] = READY;
              end else begin
                cnt_d[i] = cnt_q[i] - 1'b1;
              end
            end
            default: begin
              state_d[i]  = DEAD;
              health_d[i] = 3'd0;
            end
          endcase
        end
        // Round over: everything holds so the result screen shows final values
        3'd3, 3'd4, 3'd5: begin
        end
        default: begin
          health_d[i] = MAX_HEALTH;
          state_d[i]  = READY;
          cnt_d[i]    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q <= 2'b00;
      ack_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        health_q[i] <= MAX_HEALTH;
        state_q[i]  <= READY;
        cnt_q[i]    <= '0;
`ifdef HEALTH_REGEN_EN
        regen_q[i]  <= '0;
`endif
      end
    end else begin
      hit_q <= hit_d;
      ack_q <= ack_d;
      for (int i = 0; i < 2; i++) begin
        health_q[i] <= health_d[i];
        state_q[i]  <= state_d[i];
        cnt_q[i]    <= cnt_d[i];
`ifdef HEALTH_REGEN_EN
        regen_q[i]  <= regen_d[i];
`endif
      end
    end
  end

  assign player1_health = health_q[0];
  assign player2_health = health_q[1];
  assign p1_invuln      = (state_q[0] == IFRAME);
  assign p2_invuln      = (state_q[1] == IFRAME);
  assign p1_dmg_ack     = ack_q[0];
  assign p2_dmg_ack     = ack_q[1];

endmodule

// File: tb/tb_health_tracker.sv
// Directed bench for health_tracker: damage, i-frames, saturation, edge qualification, freeze, reset.
module tb_health_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] game_state;
  logic       p1_hit, p2_hit, p1_heavy, p2_heavy, p1_block, p2_block;
  logic [2:0] player1_health, player2_health;
  logic       p1_invuln, p2_invuln, p1_dmg_ack, p2_dmg_ack;

  int cmps = 0;
  int errs = 0;

  health_tracker dut (
    .clk(clk), .reset(reset), .game_state(game_state),
    .p1_hit(p1_hit), .p2_hit(p2_hit), .p1_heavy(p1_heavy), .p2_heavy(p2_heavy),
    .p1_block(p1_block), .p2_block(p2_block),
    .player1_health(player1_health), .player2_health(player2_health),
    .p1_invuln(p1_invuln), .p2_invuln(p2_invuln),
    .p1_dmg_ack(p1_dmg_ack), .p2_dmg_ack(p2_dmg_ack)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; game_state = 3'd2;
    p1_hit = 0; p2_hit = 0; p1_heavy = 0; p2_heavy = 0; p1_block = 0; p2_block = 0;
    #1;
    cmps++; if (player1_health !== 3'd5) begin errs++; $display("FAIL reset_p1_health got %0d want 5", player1_health); end
    cmps++; if (player2_health !== 3'd5) begin errs++; $display("FAIL reset_p2_health got %0d want 5", player2_health); end
    cmps++; if ({p1_invuln, p2_invuln, p1_dmg_ack, p2_dmg_ack} !== 4'b0000) begin errs++;
      $display("FAIL reset_flags got %b want 0000", {p1_invuln, p2_invuln, p1_dmg_ack, p2_dmg_ack}); end
    step(2);
    reset = 1'b0;
    step();
  endtask

  task automatic test_hit_iframes;
    int inv_cnt;
    logic bad;
    p1_hit = 1; step();
    cmps++; if (player1_health !== 3'd4) begin errs++; $display("FAIL hit1_health got %0d want 4", player1_health); end
    cmps++; if (p1_dmg_ack !== 1'b1) begin errs++; $display("FAIL hit1_ack got %b want 1", p1_dmg_ack); end
    inv_cnt = p1_invuln ? 1 : 0;
    bad = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      p1_hit = (i == 10);
      step();
      if (p1_invuln) inv_cnt++;
      if (player1_health !== 3'd4 || p1_dmg_ack !== 1'b0) bad = 1'b1;
    end
    cmps++; if (inv_cnt !== 30) begin errs++; $display("FAIL iframe_len got %0d want 30", inv_cnt); end
    cmps++; if (bad !== 1'b0) begin errs++; $display("FAIL iframe_hit_ignored got %0d want 4 with no ack", player1_health); end
    p1_hit = 1; step();
    cmps++; if (player1_health !== 3'd3 || p1_dmg_ack !== 1'b1) begin errs++;
      $display("FAIL hit2 got health %0d ack %b want 3 ack 1", player1_health, p1_dmg_ack); end
    p1_hit = 0; step();
    cmps++; if (p1_dmg_ack !== 1'b0) begin errs++; $display("FAIL ack_one_cycle got %b want 0", p1_dmg_ack); end
  endtask

  task automatic test_saturate_dead;
    p2_heavy = 1;
    p2_hit = 1; step(); p2_hit = 0;
    cmps++; if (player2_health !== 3'd3) begin errs++; $display("FAIL heavy1 got %0d want 3", player2_health); end
    step(31);
    p2_hit = 1; step(); p2_hit = 0;
    cmps++; if (player2_health !== 3'd1) begin errs++; $display("FAIL heavy2 got %0d want 1", player2_health); end
    step(31);
    p2_hit = 1; step(); p2_hit = 0;
    cmps++; if (player2_health !== 3'd0 || p2_dmg_ack !== 1'b1 || p2_invuln !== 1'b0) begin errs++;
      $display("FAIL saturate got health %0d ack %b inv %b want 0 1 0", player2_health, p2_dmg_ack, p2_invuln); end
    step(2);
    p2_hit = 1; step(); p2_hit = 0;
    cmps++; if (player2_health !== 3'd0 || p2_dmg_ack !== 1'b0) begin errs++;
      $display("FAIL dead_ignores got health %0d ack %b want 0 0", player2_health, p2_dmg_ack); end
    p2_heavy = 0;
    step();
  endtask

  task automatic test_simultaneous;
    game_state = 3'd0; step();
    cmps++; if (player1_health !== 3'd5 || player2_health !== 3'd5) begin errs++;
      $display("FAIL idle_reload got %0d %0d want 5 5", player1_health, player2_health); end
    game_state = 3'd2;
    p1_heavy = 1; p2_heavy = 1;
    p1_hit = 1; p2_hit = 1; step(); p1_hit = 0; p2_hit = 0; step(31);
    p1_hit = 1; p2_hit = 1; step(); p1_hit = 0; p2_hit = 0; step(31);
    cmps++; if (player1_health !== 3'd1 || player2_health !== 3'd1) begin errs++;
      $display("FAIL both_heavy got %0d %0d want 1 1", player1_health, player2_health); end
    p1_heavy = 0; p2_heavy = 0;
    p1_hit = 1; p2_hit = 1; step(); p1_hit = 0; p2_hit = 0;
    cmps++; if ({player1_health, player2_health, p1_dmg_ack, p2_dmg_ack} !== 8'b000_000_11) begin errs++;
      $display("FAIL both_dead got %0d %0d acks %b%b want 0 0 acks 11",
               player1_health, player2_health, p1_dmg_ack, p2_dmg_ack); end
    step();
  endtask

  task automatic test_frozen;
    game_state = 3'd6; step();
    cmps++; if (player1_health !== 3'd5 || player2_health !== 3'd5) begin errs++;
      $display("FAIL state6_reload got %0d %0d want 5 5", player1_health, player2_health); end
    game_state = 3'd2;
    p1_hit = 1; step(); p1_hit = 0; step(5);
    game_state = 3'd3; step(3);
    p1_hit = 1; step(); p1_hit = 0; step();
    cmps++; if (player1_health !== 3'd4 || p1_invuln !== 1'b1 || p1_dmg_ack !== 1'b0) begin errs++;
      $display("FAIL frozen got health %0d inv %b ack %b want 4 1 0", player1_health, p1_invuln, p1_dmg_ack); end
    game_state = 3'd2; step();
    cmps++; if (p1_invuln !== 1'b1) begin errs++; $display("FAIL resume_iframe got %b want 1", p1_invuln); end
    step(30);
    cmps++; if (p1_invuln !== 1'b0 || player1_health !== 3'd4) begin errs++;
      $display("FAIL resume_ready got inv %b health %0d want 0 4", p1_invuln, player1_health); end
  endtask

  task automatic test_edge_block;
    game_state = 3'd1; p1_hit = 1; step();
    game_state = 3'd2; step();
    cmps++; if (player1_health !== 3'd5 || p1_dmg_ack !== 1'b0) begin errs++;
      $display("FAIL held_across_fight got %0d ack %b want 5 0", player1_health, p1_dmg_ack); end
    step(3);
    cmps++; if (player1_health !== 3'd5) begin errs++; $display("FAIL held_counts_once got %0d want 5", player1_health); end
    p1_hit = 0; step();
    p1_block = 1; p1_hit = 1; step();
    cmps++; if (player1_health !== 3'd5 || p1_dmg_ack !== 1'b0 || p1_invuln !== 1'b0) begin errs++;
      $display("FAIL blocked got %0d ack %b inv %b want 5 0 0", player1_health, p1_dmg_ack, p1_invuln); end
    p1_hit = 0; p1_block = 0; step();
  endtask

  task automatic test_regen;
    p1_heavy = 1; p1_hit = 1; step(); p1_hit = 0; p1_heavy = 0;
    cmps++; if (player1_health !== 3'd3) begin errs++; $display("FAIL regen_setup got %0d want 3", player1_health); end
    step(209);
    cmps++; if (player1_health !== 3'd3) begin errs++; $display("FAIL regen_early got %0d want 3", player1_health); end
    step();
`ifdef HEALTH_REGEN_EN
    cmps++; if (player1_health !== 3'd4) begin errs++; $display("FAIL regen_applied got %0d want 4", player1_health); end
`else
    cmps++; if (player1_health !== 3'd3) begin errs++; $display("FAIL no_regen got %0d want 3", player1_health); end
`endif
  endtask

  task automatic test_async_reset;
    game_state = 3'd0; step(); game_state = 3'd2;
    p1_hit = 1; step(); p1_hit = 0; step(3);
    cmps++; if (p1_invuln !== 1'b1 || player1_health !== 3'd4) begin errs++;
      $display("FAIL pre_reset got inv %b health %0d want 1 4", p1_invuln, player1_health); end
    #2 reset = 1'b1;
    #1;
    cmps++; if (player1_health !== 3'd5 || p1_invuln !== 1'b0) begin errs++;
      $display("FAIL async_reset got health %0d inv %b want 5 0", player1_health, p1_invuln); end
    step(2);
    reset = 1'b0;
    step(2);
    cmps++; if (player1_health !== 3'd5 || p1_invuln !== 1'b0) begin errs++;
      $display("FAIL post_reset got health %0d inv %b want 5 0", player1_health, p1_invuln); end
  endtask

  initial begin
    test_reset();
    test_hit_iframes();
    test_saturate_dead();
    test_simultaneous();
    test_frozen();
    test_edge_block();
    test_regen();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
